lcg_seed_search: RTL and testbench

Parametrised, pipelined seed-recovery engine for linear congruential generators x' = (x·A + C) mod M. Given the generator constants, a seed range and N_OBS consecutive observed outputs, it scans the range with LANES candidates per clock and reports the lowest seed whose first N_OBS outputs match. It is the search core of the FPGA guessing design, driven by a host/controller over a start/done handshake.

---
 rtl/lcg_seed_search_pkg.sv | 8 +
 rtl/lcg_seed_search_if.sv | 10 +
 rtl/lcg_seed_search_step.sv | 37 +++
 rtl/lcg_seed_search.sv | 109 ++++++++++
 tb/tb_lcg_seed_search.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/lcg_seed_search_pkg.sv
// lcg_seed_search_pkg: shared FSM state type, default word width and the obs slice offset helper
package lcg_seed_search_pkg;
  localparam int W_DEF = 32;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic int obs_lsb(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/lcg_seed_search_if.sv
// lcg_seed_search_if: host bus (start, M/A/C, seed range, obs in; busy, done, found, seed_out back)
interface lcg_seed_search_if #(parameter int W = 32, parameter int N_OBS = 3);
  logic start;
  logic [W-1:0] modulus, multiplier, increment, seed_lo, seed_hi;
  logic [N_OBS*W-1:0] obs;
  logic busy, done, found;
  logic [W-1:0] seed_out;
  modport master(output start, modulus, multiplier, increment, seed_lo, seed_hi, obs, input busy, done, found, seed_out);
  modport slave(input start, modulus, multiplier, increment, seed_lo, seed_hi, obs, output busy, done, found, seed_out);
endinterface

// File: rtl/lcg_seed_search_step.sv
// lcg_step: one registered stage x' = (x*a + c) mod m with seed/valid carried alongside and a running match bit
module lcg_step #(parameter int W = 32) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         flush,
  input  logic [W-1:0] a,
  input  logic [W-1:0] c,
  input  logic [W-1:0] m,
  input  logic [W-1:0] exp_x,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] seed_in,
  input  logic         valid_in,
  input  logic         match_in,
  output logic [W-1:0] x_out,
  output logic [W-1:0] seed_out,
  output logic         valid_out,
  output logic         match_out
);
  logic [2*W-1:0] prod;
  logic [W-1:0] x_nx;
  always_comb begin
    prod = (2*W)'(x_in) * (2*W)'(a) + (2*W)'(c);
    x_nx = W'(prod % (2*W)'(m));
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      x_out <= '0;
      seed_out <= '0;
      valid_out <= 1'b0;
      match_out <= 1'b0;
    end else begin
      x_out <= x_nx;
      seed_out <= seed_in;
      valid_out <= valid_in && !flush;
      match_out <= match_in && x_nx == exp_x;
    end
endmodule

// File: rtl/lcg_seed_search.sv
// lcg_seed_search: scans seed_lo..seed_hi, LANES seeds/clock through an N_OBS-deep LCG pipe; CLK/RST plus slave bus
module lcg_seed_search
  import lcg_seed_search_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N_OBS = 3,
  parameter int LANES = 2
) (
  input logic CLK,
  input logic RST,
  lcg_seed_search_if.slave bus
);
  state_t state, state_nx;
  logic [W-1:0] m_r, a_r, c_r, hi_r, seed_r, hit_seed;
  logic [N_OBS*W-1:0] obs_r;
  logic [W:0] base;
  logic bad_r, found_r, accept, hit, issue, last, pipe_busy;
  logic [W-1:0] s0 [LANES];
  logic v0 [LANES];
  logic [W-1:0] xo [N_OBS][LANES];
  logic [W-1:0] so [N_OBS][LANES];
  logic vo [N_OBS][LANES];
  logic mo [N_OBS][LANES];
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar k = 0; k < N_OBS; k++) begin : g_stage
      logic [W-1:0] xi, si;
      logic vi, mi;
      if (k == 0) begin : g_in
        assign xi = s0[l];
        assign si = s0[l];
        assign vi = v0[l];
        assign mi = 1'b1;
      end else begin : g_in
        assign xi = xo[k-1][l];
        assign si = so[k-1][l];
        assign vi = vo[k-1][l];
        assign mi = mo[k-1][l];
      end
      lcg_step #(.W(W)) u_step (
        .CLK(CLK), .RST(RST), .flush(hit), .a(a_r), .c(c_r), .m(m_r),
        .exp_x(obs_r[obs_lsb(k, W) +: W]), .x_in(xi), .seed_in(si), .valid_in(vi), .match_in(mi),
        .x_out(xo[k][l]), .seed_out(so[k][l]), .valid_out(vo[k][l]), .match_out(mo[k][l])
      );
    end
  end
  always_comb begin
    accept = bus.start && (state == IDLE || state == DONE);
    hit = 1'b0;
    hit_seed = '0;
    pipe_busy = 1'b0;
    for (int l = LANES - 1; l >= 0; l--)
      if (vo[N_OBS-1][l] && mo[N_OBS-1][l]) begin
        hit = 1'b1;
        hit_seed = so[N_OBS-1][l];
      end
    for (int l = 0; l < LANES; l++) begin
      pipe_busy |= v0[l];
      for (int k = 0; k < N_OBS - 1; k++) pipe_busy |= vo[k][l];
    end
    issue = state == RUN && !bad_r && !hit;
    last = base + (W+1)'(LANES) > {1'b0, hi_r};
    state_nx = (state == IDLE || state == DONE) ? (accept ? RUN : state) :
               (hit || (state == DRAIN && !pipe_busy)) ? DONE :
               (state == RUN && (bad_r || last)) ? DRAIN : state;
    bus.busy = state == RUN || state == DRAIN;
    bus.done = state == DONE;
  end
  assign bus.found = found_r;
  assign bus.seed_out = seed_r;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      m_r <= '0;
      a_r <= '0;
      c_r <= '0;
      hi_r <= '0;
      obs_r <= '0;
      bad_r <= 1'b0;
      base <= '0;
      found_r <= 1'b0;
      seed_r <= '0;
      for (int l = 0; l < LANES; l++) begin
        s0[l] <= '0;
        v0[l] <= 1'b0;
      end
    end else begin
      if (accept) begin
        m_r <= bus.modulus;
        a_r <= bus.multiplier;
        c_r <= bus.increment;
        hi_r <= bus.seed_hi;
        obs_r <= bus.obs;
        bad_r <= bus.modulus == '0 || bus.seed_hi < bus.seed_lo;
        base <= {1'b0, bus.seed_lo};
        found_r <= 1'b0;
        seed_r <= '0;
      end else if (issue) base <= base + (W+1)'(LANES);
      if (hit) begin
        found_r <= 1'b1;
        seed_r <= hit_seed;
      end
      for (int l = 0; l < LANES; l++) begin
        s0[l] <= W'(base + (W+1)'(l));
        v0[l] <= issue && base + (W+1)'(l) <= {1'b0, hi_r};
      end
    end
endmodule

// File: tb/tb_lcg_seed_search.sv
// tb_lcg_seed_search: scoreboard bench for two lcg_seed_search configurations against a brute-force reference
module tb_lcg_seed_search;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  typedef struct {int lat; bit f; logic [31:0] s;} exp_t;
  exp_t sb [$];
  lcg_seed_search_if #(.W(32), .N_OBS(3)) ifa ();
  lcg_seed_search_if #(.W(32), .N_OBS(1)) ifb ();
  lcg_seed_search #(.W(32), .N_OBS(3), .LANES(2)) dut_a (.CLK(CLK), .RST(RST), .bus(ifa));
  lcg_seed_search #(.W(32), .N_OBS(1), .LANES(4)) dut_b (.CLK(CLK), .RST(RST), .bus(ifb));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] nx(input logic [31:0] x, a, c, m);
    logic [63:0] p;
    p = (64'(x) * 64'(a) + 64'(c)) % 64'(m);
    return p[31:0];
  endfunction
  function automatic logic [95:0] mk_obs(input logic [31:0] s, m, a, c);
    logic [95:0] o;
    logic [31:0] x;
    x = s;
    for (int k = 0; k < 3; k++) begin
      x = nx(x, a, c, m);
      o[k*32 +: 32] = x;
    end
    return o;
  endfunction
  task automatic ref_search(input logic [31:0] m, a, c, lo, hi, input logic [95:0] o, input int n, input int lanes, output exp_t e);
    logic [31:0] x;
    bit ok;
    e.f = 0;
    e.s = 0;
    if (m == 0 || hi < lo) begin
      e.lat = 2;
      return;
    end
    for (longint sd = longint'(lo); sd <= longint'(hi) && !e.f; sd++) begin
      x = sd[31:0];
      ok = 1;
      for (int k = 0; k < n; k++) begin
        x = nx(x, a, c, m);
        if (x != o[k*32 +: 32]) ok = 0;
      end
      if (ok) begin
        e.f = 1;
        e.s = sd[31:0];
      end
    end
    e.lat = e.f ? int'((e.s - lo) / lanes) + n + 2 : int'((longint'(hi) - longint'(lo) + lanes) / lanes) + n + 1;
  endtask
  function automatic logic bz(input int d);
    return d == 0 ? ifa.busy : ifb.busy;
  endfunction
  function automatic logic dn(input int d);
    return d == 0 ? ifa.done : ifb.done;
  endfunction
  function automatic logic fd(input int d);
    return d == 0 ? ifa.found : ifb.found;
  endfunction
  function automatic logic [31:0] so(input int d);
    return d == 0 ? ifa.seed_out : ifb.seed_out;
  endfunction
  task automatic drive(input int d, input logic [31:0] m, a, c, lo, hi, input logic [95:0] o);
    if (d == 0) begin
      ifa.modulus = m; ifa.multiplier = a; ifa.increment = c;
      ifa.seed_lo = lo; ifa.seed_hi = hi; ifa.obs = o; ifa.start = 1;
    end else begin
      ifb.modulus = m; ifb.multiplier = a; ifb.increment = c;
      ifb.seed_lo = lo; ifb.seed_hi = hi; ifb.obs = o[31:0]; ifb.start = 1;
    end
  endtask
  task automatic go(input int d, input logic [31:0] m, a, c, lo, hi, input logic [95:0] o, input bit pulse);
    exp_t e;
    int cyc;
    bit seen, both;
    ref_search(m, a, c, lo, hi, o, d == 0 ? 3 : 1, d == 0 ? 2 : 4, e);
    sb.push_back(e);
    @(negedge CLK);
    drive(d, m, a, c, lo, hi, o);
    @(negedge CLK);
    ifa.start = 0;
    ifb.start = 0;
    chk("busy_after_start", bz(d), 1);
    chk("done_cleared", dn(d), 0);
    cyc = 0;
    seen = 0;
    both = 0;
    while (!seen && cyc < 2000) begin
      if (pulse && cyc == 5) begin ifa.start = 1; ifa.modulus = 0; ifa.seed_hi = 0; end
      if (pulse && cyc == 6) ifa.start = 0;
      @(negedge CLK);
      cyc++;
      if (bz(d) && dn(d)) both = 1;
      seen = dn(d);
    end
    chk("done_seen", seen, 1);
    e = sb.pop_front();
    chk("latency", cyc, e.lat);
    chk("found", fd(d), e.f);
    chk("seed_out", so(d), e.s);
    chk("busy_done_excl", both, 0);
  endtask
  initial begin
    logic [95:0] o1;
    logic [31:0] m, a, c, lo, hi, s;
    {ifa.start, ifa.modulus, ifa.multiplier, ifa.increment, ifa.seed_lo, ifa.seed_hi, ifa.obs} = '0;
    {ifb.start, ifb.modulus, ifb.multiplier, ifb.increment, ifb.seed_lo, ifb.seed_hi, ifb.obs} = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_found", ifa.found, 0);
    chk("rst_seed", ifa.seed_out, 0);
    RST = 0;
    o1 = mk_obs(96, 993441, 4001, 60211);
    chk("obs_plan", o1, {32'd127141, 32'd466569, 32'd444307});
    go(0, 993441, 4001, 60211, 0, 200, o1, 0);
    go(0, 993441, 4001, 60211, 96, 300, o1, 0);
    go(0, 993441, 4001, 60211, 10, 9, o1, 0);
    go(0, 0, 4001, 60211, 0, 200, o1, 0);
    go(0, 1000003, 12345, 67, 32'hFFFF_FFFD, 32'hFFFF_FFFF, mk_obs(0, 1000003, 12345, 67), 0);
    go(0, 993441, 4001, 60211, 0, 200, o1, 1);
    #2 RST = 1;
    #1;
    chk("rst_done_async", ifa.done, 0);
    chk("rst_found_async", ifa.found, 0);
    chk("rst_seed_async", ifa.seed_out, 0);
    @(negedge CLK);
    RST = 0;
    drive(0, 993441, 4001, 60211, 0, 200, o1);
    @(negedge CLK);
    ifa.start = 0;
    repeat (10) @(negedge CLK);
    chk("busy_mid_run", ifa.busy, 1);
    #2 RST = 1;
    #1;
    chk("rst_mid_busy", ifa.busy, 0);
    chk("rst_mid_done", ifa.done, 0);
    @(negedge CLK);
    RST = 0;
    go(0, 993441, 4001, 60211, 0, 200, o1, 0);
    go(1, 16, 5, 3, 0, 15, 96'd8, 0);
    go(1, 16, 8, 3, 0, 15, 96'd11, 0);
    go(1, 16, 8, 3, 2, 15, 96'd11, 0);
    go(1, 16, 8, 3, 10, 9, 96'd11, 0);
    for (int i = 0; i < 3; i++) begin
      m = $urandom_range(1000, 50);
      a = $urandom_range(m - 1, 1);
      c = $urandom_range(m - 1, 0);
      lo = $urandom_range(100, 0);
      hi = lo + $urandom_range(60, 10);
      s = $urandom_range(hi, lo);
      go(0, m, a, c, lo, hi, mk_obs(s, m, a, c), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
